// File: rtl/adder_fault_checker.sv
// Purpose : recomputes a WIDTH-bit sum CHUNK bits per cycle (LSB first) and compares it with the
//           sum an adder under fault injection produced; reports fault flag, error mask, lowest
//           faulty bit index, and keeps saturating check/fault counters.
// Latency : result valid N = WIDTH/CHUNK cycles after the acceptance edge; back-to-back spacing N+2.
// Backpressure: in_ready is low outside IDLE; the result is held in REPORT until out_ready.
// Ports   : clock/reset (async, active-high); in_* transaction with valid/ready; out_valid/out_ready
//           result handshake with fault_detected, fault_mask, fault_bit; check_count, fault_count,
//           clear_counts; fault_sticky.
// Option  : define ADDER_CHECK_STICKY_EN to build the sticky fault flag (tied to 0 otherwise).
module adder_fault_checker #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_cin,
    input  logic [WIDTH-1:0]         in_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     fault_detected,
    output logic [WIDTH-1:0]         fault_mask,
    output logic [$clog2(WIDTH)-1:0] fault_bit,
    output logic [CNT_W-1:0]         check_count,
    output logic [CNT_W-1:0]         fault_count,
    input  logic                     clear_counts,
    output logic                     fault_sticky
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int BIT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d, mask_q, mask_d;
    logic               carry_q, carry_d, found_q, found_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BIT_W-1:0]   low_q, low_d;
    logic               fdet_q, fdet_d;
    logic [WIDTH-1:0]   fmask_q, fmask_d;
    logic [BIT_W-1:0]   fbit_q, fbit_d;
    logic [CNT_W-1:0]   chk_cnt_q, chk_cnt_d, flt_cnt_q, flt_cnt_d;

    // Per-chunk datapath
    logic [CHUNK-1:0]   a_chunk, b_chunk, s_chunk, chunk_mism;
    logic [CHUNK:0]     chunk_add;
    logic [BIT_W-1:0]   chunk_low;
    logic [WIDTH-1:0]   mask_nxt;
    logic               last_chunk, handshake;

    always_comb begin
        a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
        s_chunk    = sum_q[idx_q*CHUNK +: CHUNK];
        chunk_add  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        chunk_mism = chunk_add[CHUNK-1:0] ^ s_chunk;
        // Scan MSB to LSB so the last hit is the lowest mismatching bit.
        chunk_low  = '0;
        for (int j = CHUNK - 1; j >= 0; j--) begin
            if (chunk_mism[j]) begin
                chunk_low = BIT_W'(int'(idx_q) * CHUNK + j);
            end
        end
        mask_nxt = mask_q;
        mask_nxt[idx_q*CHUNK +: CHUNK] = chunk_mism;
        last_chunk = (idx_q == IDX_W'(N - 1));
        handshake  = (state_q == REPORT) && out_ready;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        mask_d    = mask_q;
        carry_d   = carry_q;
        found_d   = found_q;
        idx_d     = idx_q;
        low_d     = low_q;
        fdet_d    = fdet_q;
        fmask_d   = fmask_q;
        fbit_d    = fbit_q;
        chk_cnt_d = chk_cnt_q;
        flt_cnt_d = flt_cnt_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == REPORT);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sum_d   = in_sum;
                    carry_d = in_cin;
                    idx_d   = '0;
                    mask_d  = '0;
                    found_d = 1'b0;
                    low_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                mask_d  = mask_nxt;
                carry_d = chunk_add[CHUNK];
                idx_d   = idx_q + IDX_W'(1);
                if (!found_q && (chunk_mism != '0)) begin
                    found_d = 1'b1;
                    low_d   = chunk_low;
                end
                // Result registers load only here so they stay stable in REPORT and hold in IDLE.
                if (last_chunk) begin
                    fmask_d = mask_nxt;
                    fdet_d  = (mask_nxt != '0);
                    fbit_d  = (!found_q && (chunk_mism != '0)) ? chunk_low : low_q;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over a same-edge increment.
        if (clear_counts) begin
            chk_cnt_d = '0;
            flt_cnt_d = '0;
        end else if (handshake) begin
            if (chk_cnt_q != '1) chk_cnt_d = chk_cnt_q + CNT_W'(1);
            if (fdet_q && (flt_cnt_q != '1)) flt_cnt_d = flt_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            mask_q    <= '0;
            carry_q   <= 1'b0;
            found_q   <= 1'b0;
            idx_q     <= '0;
            low_q     <= '0;
            fdet_q    <= 1'b0;
            fmask_q   <= '0;
            fbit_q    <= '0;
            chk_cnt_q <= '0;
            flt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            mask_q    <= mask_d;
            carry_q   <= carry_d;
            found_q   <= found_d;
            idx_q     <= idx_d;
            low_q     <= low_d;
            fdet_q    <= fdet_d;
            fmask_q   <= fmask_d;
            fbit_q    <= fbit_d;
            chk_cnt_q <= chk_cnt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign fault_detected = fdet_q;
    assign fault_mask     = fmask_q;
    assign fault_bit      = fbit_q;
    assign check_count    = chk_cnt_q;
    assign fault_count    = flt_cnt_q;

`ifdef ADDER_CHECK_STICKY_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (clear_counts) begin
            sticky_d = 1'b0;
        end else if (handshake && fdet_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign fault_sticky = sticky_q;
`else
    assign fault_sticky = 1'b0;
`endif

endmodule
